tick_generator: RTL and testbench

- Multi-channel, runtime-programmable successor to the single fixed-rate divider.
- Each of CHANNELS independent channels divides clk by a programmable terminal count.
- Each channel produces a one-cycle tick pulse and a toggling square-wave level.
- Channels run periodic or one-shot. Supplies game timers, animation frame strobes and VGA/audio enables from one block.

---
 rtl/tick_pkg.sv | 39 +++
 rtl/tick_channel.sv | 75 +++++++
 rtl/tick_generator.sv | 96 +++++++++
 tb/tb_tick_generator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// -----------------------------------------------------------------------------
// tick_pkg
// Shared definitions for the multi-channel tick generator.
//   MODE_PERIODIC / MODE_ONESHOT : encodings of the per-channel mode bit.
//   chan_width()                 : width of the channel-select field.
//   cfg_rec_t                    : staged configuration record (chan, max,
//                                  oneshot, run). Fields are sized for the
//                                  largest supported instance (16 channels,
//                                  64-bit terminal count); each instance
//                                  zero-extends into them.
// -----------------------------------------------------------------------------
package tick_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Enough bits to address the largest supported channel count (16).
    localparam int unsigned CHAN_BITS = 4;
    // Widest supported counter / terminal count.
    localparam int unsigned MAX_WIDTH = 64;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int unsigned chan_width(input int unsigned channels);
        int unsigned w;
        w = 1;
        if (channels > 1) begin
            w = $clog2(channels);
        end
        return w;
    endfunction

    typedef struct packed {
        logic [CHAN_BITS-1:0] chan;
        logic [MAX_WIDTH-1:0] max;
        logic                 oneshot;
        logic                 run;
    } cfg_rec_t;

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One divider channel: counts clk edges up to a programmable terminal count,
// emitting a one-cycle tick and toggling a square-wave level at each terminal
// count. Periodic or one-shot; a one-shot channel stops itself after its first
// terminal count.
//
// Ports:
//   clk         in   system clock, posedge
//   reset       in   synchronous active-high reset
//   apply       in   load the cfg_* fields this edge (restarts the channel)
//   cfg_max     in   WIDTH-bit terminal count to load
//   cfg_oneshot in   mode to load (MODE_PERIODIC / MODE_ONESHOT)
//   cfg_run     in   run bit to load
//   tick        out  one-cycle pulse at terminal count (registered)
//   level       out  toggles at each terminal count (registered)
//   running     out  channel run bit (registered)
// -----------------------------------------------------------------------------
module tick_channel
    import tick_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(25_000_000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             apply,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic             cfg_oneshot,
    input  logic             cfg_run,
    output logic             tick,
    output logic             level,
    output logic             running
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] max_q;
    logic             oneshot_q;

    // Priority: reset, then a configuration apply (which wins over a
    // coincident terminal count), then normal counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            max_q     <= DEFAULT_MAX;
            oneshot_q <= MODE_PERIODIC;
            running   <= 1'b1;
            tick      <= 1'b0;
            level     <= 1'b0;
        end else if (apply) begin
            count     <= '0;
            max_q     <= cfg_max;
            oneshot_q <= cfg_oneshot;
            running   <= cfg_run;
            tick      <= 1'b0;
            level     <= 1'b0;
        end else if (running) begin
            if (count == max_q) begin
                count <= '0;
                tick  <= 1'b1;
                level <= ~level;
                if (oneshot_q == MODE_ONESHOT) begin
                    running <= 1'b0;
                end
            end else begin
                count <= count + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            // Stopped: counter and level hold, tick stays low.
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
// Multi-channel, runtime-programmable clock divider. Every channel is a
// free-running divider by DEFAULT_MAX+1 out of reset. A configuration write is
// accepted on cfg_valid && cfg_ready, held in a staging register for one cycle
// (cfg_ready low), and applied to the addressed channel at the following edge.
// Writes to an index >= CHANNELS complete the handshake but change nothing.
//
// Ports:
//   clk         in   system clock, posedge
//   reset       in   synchronous active-high reset
//   cfg_valid   in   configuration write request
//   cfg_ready   out  write can be accepted this cycle (registered)
//   cfg_chan    in   CW-bit target channel index
//   cfg_max     in   WIDTH-bit terminal count
//   cfg_oneshot in   0 = periodic, 1 = one-shot
//   cfg_run     in   1 = start channel, 0 = stop channel
//   tick        out  per-channel one-cycle pulse at terminal count
//   level       out  per-channel square wave
//   running     out  per-channel run bit
// -----------------------------------------------------------------------------
module tick_generator
    import tick_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      CHANNELS    = 4,
    parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(25_000_000),
    localparam int unsigned     CW          = chan_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_max,
    input  logic                cfg_oneshot,
    input  logic                cfg_run,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] running
);

    cfg_rec_t            stage_q;
    logic [WIDTH-1:0]    staged_max;
    logic [CHANNELS-1:0] apply;

    // cfg_ready doubles as "staging register empty": when it is low a write
    // is held in stage_q and is applied at the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ready <= 1'b1;
            stage_q   <= '0;
        end else if (cfg_ready) begin
            if (cfg_valid) begin
                stage_q.chan    <= CHAN_BITS'(cfg_chan);
                stage_q.max     <= MAX_WIDTH'(cfg_max);
                stage_q.oneshot <= cfg_oneshot;
                stage_q.run     <= cfg_run;
                cfg_ready       <= 1'b0;
            end
        end else begin
            cfg_ready <= 1'b1;
        end
    end

    // The record carries a 64-bit max; anything that does not fit in WIDTH
    // saturates rather than wrapping to a short period.
    if (WIDTH < MAX_WIDTH) begin : g_max_clamp
        assign staged_max = (|stage_q.max[MAX_WIDTH-1:WIDTH]) ? '1
                                                              : stage_q.max[WIDTH-1:0];
    end else begin : g_max_full
        assign staged_max = stage_q.max[WIDTH-1:0];
    end

    // The full-width channel field is compared, so an index >= CHANNELS
    // matches no strobe and the write is silently dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign apply[g] = !cfg_ready && (stage_q.chan == CHAN_BITS'(g));

        tick_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_MAX (DEFAULT_MAX)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .apply       (apply[g]),
            .cfg_max     (staged_max),
            .cfg_oneshot (stage_q.oneshot),
            .cfg_run     (stage_q.run),
            .tick        (tick[g]),
            .level       (level[g]),
            .running     (running[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// -----------------------------------------------------------------------------
// tb_tick_generator
// Scoreboard bench for tick_generator. Two instances share clock, reset and
// the configuration bus: a 4-channel one and a 3-channel one, so that writes
// to channel 3 are in range for the first and out of range for the second.
// Expected outputs are derived per edge from each channel's last restart edge,
// terminal count and mode, pushed when stimulus is driven, and popped and
// compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_tick_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_ready3;
    logic [1:0]  cfg_chan;
    logic [31:0] cfg_max;
    logic        cfg_oneshot;
    logic        cfg_run;
    logic [3:0]  tick, level, running;
    logic [2:0]  tick3, level3, running3;

    always #5 clk = ~clk;

    tick_generator #(
        .WIDTH       (32),
        .CHANNELS    (4),
        .DEFAULT_MAX (32'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_max     (cfg_max),
        .cfg_oneshot (cfg_oneshot),
        .cfg_run     (cfg_run),
        .tick        (tick),
        .level       (level),
        .running     (running)
    );

    tick_generator #(
        .WIDTH       (32),
        .CHANNELS    (3),
        .DEFAULT_MAX (32'd4)
    ) dut3 (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready3),
        .cfg_chan    (cfg_chan),
        .cfg_max     (cfg_max),
        .cfg_oneshot (cfg_oneshot),
        .cfg_run     (cfg_run),
        .tick        (tick3),
        .level       (level3),
        .running     (running3)
    );

    typedef struct {
        logic [3:0] tick;
        logic [3:0] level;
        logic [3:0] running;
        logic       ready;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     acc_cnt  = 0;

    // Reference state: edge number of the last restart of each channel and
    // the configuration loaded at that restart.
    longint edge_n = 0;
    longint a_edge[4];
    longint mx[4];
    logic   os[4];
    logic   rn[4];
    logic   ready_m;
    logic [1:0] st_chan;
    longint st_max;
    logic   st_os;
    logic   st_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {tick, level, running} after edge edge_n for channel i.
    function automatic logic [2:0] exp_chan(input int i);
        longint d, p, n;
        d = edge_n - a_edge[i];
        p = mx[i] + 1;
        if (!rn[i]) return 3'b000;
        if (os[i]) begin
            if (d < p)  return 3'b001;
            if (d == p) return 3'b110;
            return 3'b010;
        end
        n = d / p;
        return {(d > 0) && (d % p == 0), n[0], 1'b1};
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [1:0] ch,
                              input logic [31:0] m, input logic o, input logic rr);
        exp_t x;
        logic [2:0] c;
        edge_n++;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                a_edge[i] = edge_n;
                mx[i]     = 4;
                os[i]     = 1'b0;
                rn[i]     = 1'b1;
            end
            ready_m = 1'b1;
        end else if (ready_m) begin
            if (v) begin
                st_chan = ch;
                st_max  = longint'(m);
                st_os   = o;
                st_run  = rr;
                ready_m = 1'b0;
            end
        end else begin
            a_edge[st_chan] = edge_n;
            mx[st_chan]     = st_max;
            os[st_chan]     = st_os;
            rn[st_chan]     = st_run;
            ready_m         = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            c = exp_chan(i);
            x.tick[i]    = c[2];
            x.level[i]   = c[1];
            x.running[i] = c[0];
        end
        x.ready = ready_m;
        sb.push_back(x);
    endtask

    task automatic compare_pending();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check($sformatf("tick@%0d", edge_n),     32'(tick),       32'(x.tick));
            check($sformatf("level@%0d", edge_n),    32'(level),      32'(x.level));
            check($sformatf("running@%0d", edge_n),  32'(running),    32'(x.running));
            check($sformatf("ready@%0d", edge_n),    32'(cfg_ready),  32'(x.ready));
            check($sformatf("tick3@%0d", edge_n),    32'(tick3),      32'(x.tick[2:0]));
            check($sformatf("level3@%0d", edge_n),   32'(level3),     32'(x.level[2:0]));
            check($sformatf("running3@%0d", edge_n), 32'(running3),   32'(x.running[2:0]));
            check($sformatf("ready3@%0d", edge_n),   32'(cfg_ready3), 32'(x.ready));
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] ch,
                        input logic [31:0] m, input logic o, input logic rr);
        @(negedge clk);
        compare_pending();
        if (v && cfg_ready === 1'b1) acc_cnt++;
        reset       = r;
        cfg_valid   = v;
        cfg_chan    = ch;
        cfg_max     = m;
        cfg_oneshot = o;
        cfg_run     = rr;
        model_edge(r, v, ch, m, o, rr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic write(input logic [1:0] ch, input logic [31:0] m,
                         input logic o, input logic rr);
        step(1'b0, 1'b1, ch, m, o, rr);
    endtask

    initial begin
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_chan    = '0;
        cfg_max     = '0;
        cfg_oneshot = 1'b0;
        cfg_run     = 1'b0;
        ready_m     = 1'b1;

        // Reset defaults: free-running divide by 5 on all channels.
        step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        idle(25);

        // Reprogram channel 1 to divide by 3.
        write(2'd1, 32'd2, 1'b0, 1'b1);
        idle(20);

        // One-shot on channel 2.
        write(2'd2, 32'd6, 1'b1, 1'b1);
        idle(60);

        // Land the apply edge on channel 0's terminal count.
        for (int k = 0; k < 10; k++) begin
            if (((edge_n + 2 - a_edge[0]) % (mx[0] + 1)) == 0) break;
            idle(1);
        end
        write(2'd0, 32'd3, 1'b0, 1'b1);
        idle(12);

        // max = 0 on channel 0.
        write(2'd0, 32'd0, 1'b0, 1'b1);
        idle(10);

        // Back-to-back requests on channel 3 (out of range for the 3-channel DUT).
        acc_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 2'd3, 32'(k + 1), 1'b0, 1'b1);
        end
        idle(1);
        check("accepted", 32'(acc_cnt), 32'd3);
        idle(20);

        // Stop channel 1.
        write(2'd1, 32'd2, 1'b0, 1'b0);
        idle(10);

        // Reset the cycle after a write is accepted.
        write(2'd1, 32'd7, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        idle(20);

        @(negedge clk);
        compare_pending();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
